// File: rtl/axi4l_trace_buffer.sv
// AXI4-Lite sniffer: logs completed reads/writes with timestamps
// into a first-word-fall-through FIFO for a debug register block.
module axi4l_trace_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned TS_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_FROM = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TO = '1,
  parameter bit LOG_WRITES = 1'b1,
  parameter bit LOG_READS = 1'b1,
  parameter bit FILTER_REP_READS = 1'b1,
  localparam int unsigned STRB = DATA_WIDTH / 8,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic                  clk_axi,
  input  logic                  anrst_axi,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB-1:0]       s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  clr,
  output logic                  empty,
  input  logic                  r_req,
  output logic                  r_rnw,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [STRB-1:0]       r_strb,
  output logic [1:0]            r_resp,
  output logic [TS_WIDTH-1:0]   r_tstamp,
  output logic [PW:0]           level,
  output logic [15:0]           drop_cnt,
  output logic                  proto_err
);

  typedef struct packed {
    logic                  rnw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB-1:0]       strb;
    logic [1:0]            resp;
    logic [TS_WIDTH-1:0]   ts;
  } entry_t;

  localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

  logic [TS_WIDTH-1:0]   ts;
  logic                  aw_vld, w_vld, ar_vld;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB-1:0]       w_strb;
  entry_t                wp, rp, push_e, hd;
  logic                  wp_vld, rp_vld;
  logic                  last_vld;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_data;
  logic [1:0]            last_resp;
  logic [PW:0]           wr_ptr, rd_ptr;
  entry_t                mem [DEPTH];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_done, r_done, wr_q, rd_q, rep;
  logic push, push_w, push_r, full, pop, wr_en, drop;

  // Window check via subtraction borrow so full-range bounds stay legal.
  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] lo, hi;
    lo = {1'b0, a} - {1'b0, ADDR_FROM};
    hi = {1'b0, ADDR_TO} - {1'b0, a};
    return ~lo[ADDR_WIDTH] & ~hi[ADDR_WIDTH];
  endfunction

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  assign b_done = b_hs & aw_vld & w_vld;
  assign r_done = r_hs & ar_vld;
  assign rep = FILTER_REP_READS & last_vld
             & (ar_addr == last_addr)
             & (s_axi_rdata == last_data)
             & (s_axi_rresp == last_resp);
  assign wr_q = b_done & LOG_WRITES & in_win(aw_addr);
  assign rd_q = r_done & LOG_READS & in_win(ar_addr) & ~rep;

  assign push_w = wp_vld;
  assign push_r = rp_vld & ~wp_vld;
  assign push   = wp_vld | rp_vld;
  assign push_e = wp_vld ? wp : rp;

  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign pop   = r_req & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign hd       = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign r_rnw    = hd.rnw;
  assign r_addr   = hd.addr;
  assign r_data   = hd.data;
  assign r_strb   = hd.strb;
  assign r_resp   = hd.resp;
  assign r_tstamp = hd.ts;

  always_ff @(posedge clk_axi) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= push_e;
  end

  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) ts <= '0;
    else            ts <= ts + TS_WIDTH'(1);
  end

  always_ff @(posedge clk_axi or negedge anrst_axi) begin
    if (!anrst_axi) begin
      aw_vld <= 1'b0; w_vld <= 1'b0; ar_vld <= 1'b0;
      aw_addr <= '0; ar_addr <= '0;
      w_data <= '0; w_strb <= '0;
      wp <= '0; rp <= '0; wp_vld <= 1'b0; rp_vld <= 1'b0;
      last_vld <= 1'b0; last_addr <= '0;
      last_data <= '0; last_resp <= '0;
      wr_ptr <= '0; rd_ptr <= '0;
      drop_cnt <= '0; proto_err <= 1'b0;
    end else if (clr) begin
      aw_vld <= 1'b0; w_vld <= 1'b0; ar_vld <= 1'b0;
      wp_vld <= 1'b0; rp_vld <= 1'b0; last_vld <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0;
      drop_cnt <= '0; proto_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_vld <= 1'b1; aw_addr <= s_axi_awaddr;
      end else if (b_done) aw_vld <= 1'b0;
      if (w_hs) begin
        w_vld <= 1'b1; w_data <= s_axi_wdata; w_strb <= s_axi_wstrb;
      end else if (b_done) w_vld <= 1'b0;
      if (ar_hs) begin
        ar_vld <= 1'b1; ar_addr <= s_axi_araddr;
      end else if (r_done) ar_vld <= 1'b0;
      if ((aw_hs & aw_vld & ~b_done) | (w_hs & w_vld & ~b_done)
          | (ar_hs & ar_vld & ~r_done))
        proto_err <= 1'b1;
      // A slot may be refilled on the same edge that pushes it.
      wp_vld <= wr_q;
      if (wr_q)
        wp <= '{rnw: 1'b0, addr: aw_addr, data: w_data, strb: w_strb,
                resp: s_axi_bresp, ts: ts};
      if (rd_q) begin
        rp_vld <= 1'b1;
        rp <= '{rnw: 1'b1, addr: ar_addr, data: s_axi_rdata,
                strb: {STRB{1'b1}}, resp: s_axi_rresp, ts: ts};
      end else if (push_r) rp_vld <= 1'b0;
      if (push_w) last_vld <= 1'b0;
      else if (push_r) begin
        last_vld <= 1'b1; last_addr <= rp.addr;
        last_data <= rp.data; last_resp <= rp.resp;
      end
      if (wr_en) wr_ptr <= wr_ptr + (PW + 1)'(1);
      if (pop) rd_ptr <= rd_ptr + (PW + 1)'(1);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi4l_trace_buffer.sv
// Directed bench for axi4l_trace_buffer: two instances share one sniffed
// bus (A: DEPTH=4 full window, B: DEPTH=8 window 0x100..0x1FF).
module tb_axi4l_trace_buffer;

  logic clk_axi = 1'b0;
  logic anrst_axi;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic clr_a, clr_b, r_req_a, r_req_b;

  logic        empty_a, r_rnw_a, proto_a;
  logic [31:0] r_addr_a, r_data_a, r_ts_a;
  logic [3:0]  r_strb_a;
  logic [1:0]  r_resp_a;
  logic [2:0]  level_a;
  logic [15:0] drop_a;

  logic        empty_b, r_rnw_b, proto_b;
  logic [31:0] r_addr_b, r_data_b, r_ts_b;
  logic [3:0]  r_strb_b;
  logic [1:0]  r_resp_b;
  logic [3:0]  level_b;
  logic [15:0] drop_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] ts_m;
  logic [127:0] qa[$];
  logic [127:0] qb[$];

  always #5 clk_axi = ~clk_axi;

  always @(posedge clk_axi or negedge anrst_axi)
    if (!anrst_axi) ts_m <= '0;
    else            ts_m <= ts_m + 32'd1;

  axi4l_trace_buffer #(.DEPTH(4)) u_a (
    .clk_axi(clk_axi), .anrst_axi(anrst_axi),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .clr(clr_a), .empty(empty_a), .r_req(r_req_a),
    .r_rnw(r_rnw_a), .r_addr(r_addr_a), .r_data(r_data_a),
    .r_strb(r_strb_a), .r_resp(r_resp_a), .r_tstamp(r_ts_a),
    .level(level_a), .drop_cnt(drop_a), .proto_err(proto_a)
  );

  axi4l_trace_buffer #(
    .DEPTH(8), .ADDR_FROM(32'h100), .ADDR_TO(32'h1FF)
  ) u_b (
    .clk_axi(clk_axi), .anrst_axi(anrst_axi),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .clr(clr_b), .empty(empty_b), .r_req(r_req_b),
    .r_rnw(r_rnw_b), .r_addr(r_addr_b), .r_data(r_data_b),
    .r_strb(r_strb_b), .r_resp(r_resp_b), .r_tstamp(r_ts_b),
    .level(level_b), .drop_cnt(drop_b), .proto_err(proto_b)
  );

  function automatic logic [127:0] pk(
    input logic rnw, input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input logic [1:0] rs, input logic [31:0] t);
    return {25'd0, rnw, a, d, s, rs, t};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_axi);
    awvalid = 0; awready = 0; wvalid = 0; wready = 0;
    bvalid = 0; bready = 0; arvalid = 0; arready = 0;
    rvalid = 0; rready = 0;
    clr_a = 0; clr_b = 0; r_req_a = 0; r_req_b = 0;
  endtask

  task automatic set_aw(input logic [31:0] a);
    awaddr = a; awvalid = 1; awready = 1;
  endtask
  task automatic set_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1; wready = 1;
  endtask
  task automatic set_b(input logic [1:0] rs);
    bresp = rs; bvalid = 1; bready = 1;
  endtask
  task automatic set_ar(input logic [31:0] a);
    araddr = a; arvalid = 1; arready = 1;
  endtask
  task automatic set_r(input logic [31:0] d, input logic [1:0] rs);
    rdata = d; rresp = rs; rvalid = 1; rready = 1;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] rs,
                       input bit ea, input bit eb);
    set_aw(a); set_w(d, s); tick();
    set_b(rs);
    if (ea) qa.push_back(pk(1'b0, a, d, s, rs, ts_m));
    if (eb) qb.push_back(pk(1'b0, a, d, s, rs, ts_m));
    tick(); tick();
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] rs, input bit ea, input bit eb);
    set_ar(a); tick();
    set_r(d, rs);
    if (ea) qa.push_back(pk(1'b1, a, d, 4'hF, rs, ts_m));
    if (eb) qb.push_back(pk(1'b1, a, d, 4'hF, rs, ts_m));
    tick(); tick();
  endtask

  task automatic head_cmp(input bit sel, input string tag);
    int n = 0;
    logic [127:0] obs;
    while ((sel ? empty_b : empty_a) && n < 10) begin
      tick(); n++;
    end
    chk({tag, "_avail"}, 128'(sel ? empty_b : empty_a), 128'd0);
    obs = sel ? pk(r_rnw_b, r_addr_b, r_data_b, r_strb_b, r_resp_b, r_ts_b)
              : pk(r_rnw_a, r_addr_a, r_data_a, r_strb_a, r_resp_a, r_ts_a);
    if (sel ? (qb.size() == 0) : (qa.size() == 0)) begin
      checks++; errors++;
      $error("FAIL %s: observed %0h expected no entry", tag, obs);
    end else if (sel) chk(tag, obs, qb.pop_front());
    else              chk(tag, obs, qa.pop_front());
  endtask

  task automatic pop_cmp(input bit sel, input string tag);
    head_cmp(sel, tag);
    if (sel) r_req_b = 1; else r_req_a = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    anrst_axi = 0;
    awaddr = 0; wdata = 0; wstrb = 0; bresp = 0; araddr = 0;
    rdata = 0; rresp = 0;
    tick(); tick(); tick();
    chk("rst_empty", 128'(empty_a), 128'd1);
    chk("rst_level", 128'(level_a), 128'd0);
    chk("rst_drop", 128'(drop_a), 128'd0);
    chk("rst_proto", 128'(proto_a), 128'd0);
    chk("rst_rout", pk(r_rnw_a, r_addr_a, r_data_a, r_strb_a, r_resp_a,
                      r_ts_a), 128'd0);
    anrst_axi = 1;
    // T1: AW+W same cycle at ts 2, B at ts 5
    tick(); tick();
    set_aw(32'h10); set_w(32'hDEADBEEF, 4'hF); tick();
    tick(); tick();
    set_b(2'd0);
    qa.push_back(pk(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, ts_m));
    tick();
    chk("t1_empty_at_n", 128'(empty_a), 128'd1);
    tick();
    chk("t1_empty_at_n1", 128'(empty_a), 128'd0);
    chk("t1_ts", 128'(r_ts_a), 128'd5);
    pop_cmp(0, "t1_entry");
    chk("t1_empty_after_pop", 128'(empty_a), 128'd1);
    // T2: W three cycles before AW
    set_w(32'hCAFEF00D, 4'h3); tick(); tick(); tick();
    set_aw(32'h20); tick(); tick();
    set_b(2'd0);
    qa.push_back(pk(1'b0, 32'h20, 32'hCAFEF00D, 4'h3, 2'd0, ts_m));
    tick();
    pop_cmp(0, "t2_entry");
    chk("t2_proto", 128'(proto_a), 128'd0);
    // T3: repeated read filter invalidated by a write
    do_rd(32'h30, 32'h1234, 2'd0, 1, 0);
    do_rd(32'h30, 32'h1234, 2'd0, 0, 0);
    do_wr(32'h30, 32'h55, 4'hF, 2'd2, 1, 0);
    do_rd(32'h30, 32'h1234, 2'd0, 1, 0);
    tick();
    chk("t3_level", 128'(level_a), 128'd3);
    pop_cmp(0, "t3_rd1");
    pop_cmp(0, "t3_wr");
    pop_cmp(0, "t3_rd2");
    chk("t3_empty", 128'(empty_a), 128'd1);
    // T4: B and R in the same cycle
    set_aw(32'h40); set_w(32'h11, 4'hF); set_ar(32'h44); tick();
    set_b(2'd0); set_r(32'h22, 2'd1);
    qa.push_back(pk(1'b0, 32'h40, 32'h11, 4'hF, 2'd0, ts_m));
    qa.push_back(pk(1'b1, 32'h44, 32'h22, 4'hF, 2'd1, ts_m));
    tick();
    chk("t4_level_n", 128'(level_a), 128'd0);
    tick();
    chk("t4_level_n1", 128'(level_a), 128'd1);
    chk("t4_head_rnw", 128'(r_rnw_a), 128'd0);
    tick();
    chk("t4_level_n2", 128'(level_a), 128'd2);
    pop_cmp(0, "t4_wr");
    pop_cmp(0, "t4_rd");
    // T5: overflow of a 4-deep FIFO
    for (int i = 0; i < 6; i++)
      do_rd(32'h50 + 32'(i), 32'h100 + 32'(i), 2'd0, i < 4, 0);
    tick(); tick();
    chk("t5_level", 128'(level_a), 128'd4);
    chk("t5_drop", 128'(drop_a), 128'd2);
    for (int i = 0; i < 4; i++) pop_cmp(0, $sformatf("t5_rd%0d", i));
    chk("t5_empty", 128'(empty_a), 128'd1);
    chk("t5_drop_kept", 128'(drop_a), 128'd2);
    // proto_err, then clr discarding a same-cycle W handshake
    set_aw(32'h60); tick();
    set_aw(32'h64); tick();
    chk("pe_set", 128'(proto_a), 128'd1);
    set_w(32'h77, 4'hF); clr_a = 1; tick();
    chk("clr_proto", 128'(proto_a), 128'd0);
    chk("clr_drop", 128'(drop_a), 128'd0);
    set_b(2'd0); tick(); tick(); tick();
    chk("clr_latch_gone", 128'(empty_a), 128'd1);
    chk("b_outside_empty", 128'(empty_b), 128'd1);
    chk("b_proto", 128'(proto_b), 128'd1);
    // T6: address window on instance B
    do_wr(32'hFC, 32'hA0, 4'hF, 2'd0, 1, 0);
    do_wr(32'h100, 32'hA1, 4'hF, 2'd0, 1, 1);
    do_wr(32'h1FF, 32'hA2, 4'h1, 2'd0, 1, 1);
    do_wr(32'h200, 32'hA3, 4'hF, 2'd0, 1, 0);
    tick();
    chk("t6_level_b", 128'(level_b), 128'd2);
    pop_cmp(1, "t6_0x100");
    head_cmp(1, "t6_0x1ff");
    clr_b = 1; tick();
    chk("t6_clr_empty", 128'(empty_b), 128'd1);
    chk("t6_clr_drop", 128'(drop_b), 128'd0);
    chk("t6_clr_proto", 128'(proto_b), 128'd0);
    for (int i = 0; i < 4; i++) pop_cmp(0, $sformatf("t6_a%0d", i));
    // reset while a read is open; the late R is ignored
    set_ar(32'h70); tick();
    anrst_axi = 0; tick();
    anrst_axi = 1;
    set_r(32'h99, 2'd0); tick(); tick(); tick();
    chk("rst_mid_empty", 128'(empty_a), 128'd1);
    chk("rst_mid_proto", 128'(proto_a), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
